// File: rtl/onehot_decoder_seq.sv
// Sequential CODE_W-to-2**CODE_W one-hot decoder with valid/ready on both sides.
// Optional parity checking on CODE is enabled by defining ONEHOT_DECODER_PARITY_EN.
module onehot_decoder_seq #(
   parameter  int CODE_W     = 3,
   parameter  int HOLD_BEATS = 1,
   localparam int DATA_W     = 2 ** CODE_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [CODE_W-1:0] CODE,
   input  logic              CODE_VALID,
   output logic              CODE_READY,
`ifdef ONEHOT_DECODER_PARITY_EN
   input  logic              CODE_PAR,
   output logic              PAR_ERR,
   output logic [7:0]        ERR_CNT,
`endif
   output logic [DATA_W-1:0] DATA,
   output logic              DATA_VALID,
   input  logic              DATA_READY,
   output logic              BUSY,
   output logic              DONE
);

   typedef enum logic {IDLE, SHOW} state_t;

   localparam logic [7:0] HOLD_M1 = 8'(HOLD_BEATS - 1);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   dec;
   logic                beat, final_beat, accept, code_ok, decode;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_dec
         assign dec[gi] = (CODE == CODE_W'(gi));
      end
   endgenerate

`ifdef ONEHOT_DECODER_PARITY_EN
   logic       par_err_q;
   logic [7:0] err_cnt_q;

   assign code_ok = ~(^{CODE, CODE_PAR});
   assign PAR_ERR = par_err_q;
   assign ERR_CNT = err_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         par_err_q <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         par_err_q <= accept & ~code_ok;
         if (accept && !code_ok && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
      end
   end
`else
   assign code_ok = 1'b1;
`endif

   assign accept     = CODE_VALID & CODE_READY;
   assign decode     = accept & code_ok;
   assign beat       = DATA_VALID & DATA_READY;
   assign final_beat = beat & (cnt_q == 8'd0);

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; a final beat may reload a new code with no bubble
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (decode) begin
               state_d = SHOW;
               data_d  = dec;
               cnt_d   = HOLD_M1;
            end
         end
         SHOW: begin
            if (beat) begin
               if (cnt_q != 8'd0) begin
                  cnt_d = cnt_q - 8'd1;
               end else if (decode) begin
                  data_d = dec;
                  cnt_d  = HOLD_M1;
               end else begin
                  state_d = IDLE;
                  data_d  = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs; RST masks the handshake and DONE so a dropped word never completes
   always_comb begin
      CODE_READY = 1'b0;
      case (state_q)
         IDLE:    CODE_READY = EN & ~RST;
         SHOW:    CODE_READY = EN & DATA_READY & (cnt_q == 8'd0) & ~RST;
         default: CODE_READY = 1'b0;
      endcase
      DATA_VALID = (state_q == SHOW);
      BUSY       = (state_q == SHOW);
      DATA       = (state_q == SHOW) ? data_q : '0;
      DONE       = final_beat & ~RST;
   end

endmodule
